// File: rtl/pipe_tx_width_adapter.sv
// -----------------------------------------------------------------------------
// pipe_tx_width_adapter
//
// Purpose:
//   Takes one 32-bit TX symbol dword per valid/ready handshake from the MAC,
//   with one K flag per byte. It serialises that dword onto the PIPE TxData
//   bus at the width selected when the dword was accepted: 8, 16 or 32 bits.
//   Byte 0 is sent first. Lanes above the active width carry IDLE_FILL with
//   K = 0. While a dword still has beats to send, the MAC is backpressured.
//
// Ports:
//   pclk          in   PIPE clock, rising edge
//   reset         in   asynchronous, active-high reset
//   width_sel     in   2  0=8b, 1=16b, 2=32b, 3=reserved (same as 32b)
//   in_valid      in   1  MAC dword valid
//   in_ready      out  1  dword can be accepted this cycle
//   in_data       in   32 symbol dword, byte0 = [7:0] transmitted first
//   in_datak      in   4  K flag per byte
//   tx_data       out  32 PIPE TxData, active lanes in the low bits
//   tx_datak      out  4  PIPE TxDataK per active byte lane
//   tx_data_valid out  1  PIPE TxDataValid
//   busy          out  1  a held dword still has beats to send
// -----------------------------------------------------------------------------
module pipe_tx_width_adapter #(
    parameter logic [7:0] IDLE_FILL = 8'h00
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [1:0]  width_sel,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [3:0]  in_datak,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_datak,
    output logic        tx_data_valid,
    output logic        busy
);

    typedef enum logic {
        S_EMPTY   = 1'b0,
        S_SENDING = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        W_8B  = 2'd0,
        W_16B = 2'd1,
        W_32B = 2'd2,
        W_RSV = 2'd3
    } pipe_data_width_e;

    state_e           state_q, state_d;
    pipe_data_width_e wl_q, wl_d;
    logic [1:0]       bc_q, bc_d;
    logic [31:0]      data_q, data_d;
    logic [3:0]       k_q, k_d;

    logic             last_beat;
    logic             accept;

    // The beat on tx this cycle is the final one of the held dword.
    always_comb begin
        last_beat = 1'b0;
        unique case (wl_q)
            W_8B:    last_beat = (bc_q == 2'd3);
            W_16B:   last_beat = (bc_q == 2'd1);
            default: last_beat = 1'b1;
        endcase
    end

    // Ready on the last beat, so the next dword follows with no idle gap.
    assign in_ready = (state_q == S_EMPTY) || last_beat;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == S_SENDING);

    // Next-state logic. in_data/in_datak are only captured on accept.
    always_comb begin
        state_d = state_q;
        wl_d    = wl_q;
        bc_d    = bc_q;
        data_d  = data_q;
        k_d     = k_q;
        if (accept) begin
            state_d = S_SENDING;
            wl_d    = pipe_data_width_e'(width_sel);
            bc_d    = 2'd0;
            data_d  = in_data;
            k_d     = in_datak;
        end else if (state_q == S_SENDING) begin
            if (last_beat) begin
                state_d = S_EMPTY;
                bc_d    = 2'd0;
            end else begin
                bc_d = bc_q + 2'd1;
            end
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
            wl_q    <= W_8B;
            bc_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            wl_q    <= wl_d;
            bc_q    <= bc_d;
        end
    end

    // Payload holding registers. Their contents are ignored unless the state
    // is SENDING, so a reset does not need to clear them.
    always_ff @(posedge pclk) begin
        data_q <= data_d;
        k_q    <= k_d;
    end

    // The output lanes are decoded only from registered state. A beat appears
    // one cycle after accept, and an async reset blanks the bus immediately.
    always_comb begin
        tx_data       = {4{IDLE_FILL}};
        tx_datak      = 4'b0000;
        tx_data_valid = 1'b0;
        if (state_q == S_SENDING) begin
            tx_data_valid = 1'b1;
            unique case (wl_q)
                W_8B: begin
                    tx_data[7:0] = data_q[{bc_q, 3'b000} +: 8];
                    tx_datak[0]  = k_q[bc_q];
                end
                W_16B: begin
                    tx_data[15:0] = bc_q[0] ? data_q[31:16] : data_q[15:0];
                    tx_datak[1:0] = bc_q[0] ? k_q[3:2] : k_q[1:0];
                end
                default: begin
                    tx_data  = data_q;
                    tx_datak = k_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_tx_width_adapter.sv
module tb_pipe_tx_width_adapter;

    localparam logic [7:0] IDLE = 8'hC3;

    logic        pclk;
    logic        reset;
    logic [1:0]  width_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_datak;
    logic [31:0] tx_data;
    logic [3:0]  tx_datak;
    logic        tx_data_valid;
    logic        busy;

    pipe_tx_width_adapter #(.IDLE_FILL(IDLE)) dut (
        .pclk          (pclk),
        .reset         (reset),
        .width_sel     (width_sel),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_datak      (in_datak),
        .tx_data       (tx_data),
        .tx_datak      (tx_datak),
        .tx_data_valid (tx_data_valid),
        .busy          (busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
    } beat_t;

    beat_t q[$];
    int    total = 0;
    int    bad   = 0;
    int    run_len  = 0;
    int    last_run = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Build the expected beats for one dword at width w and queue them.
    task automatic push_expected(input logic [31:0] d, input logic [3:0] k, input logic [1:0] w);
        beat_t b;
        if (w == 2'd0) begin
            for (int i = 0; i < 4; i++) begin
                b.d = {IDLE, IDLE, IDLE, 8'(d >> (8 * i))};
                b.k = {3'b000, k[i]};
                q.push_back(b);
            end
        end else if (w == 2'd1) begin
            for (int i = 0; i < 2; i++) begin
                b.d = {IDLE, IDLE, 16'(d >> (16 * i))};
                b.k = {2'b00, 2'(k >> (2 * i))};
                q.push_back(b);
            end
        end else begin
            b.d = d;
            b.k = k;
            q.push_back(b);
        end
    endtask

    // Offer a dword and wait, bounded, until it is accepted. On return we are
    // 1 time unit after the accept edge, and in_valid is still high.
    task automatic send(input logic [31:0] d, input logic [3:0] k, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_datak = k;
        waits    = 0;
        while (!in_ready && waits < 50) begin
            @(posedge pclk);
            #1;
            waits++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        push_expected(d, k, width_sel);
        @(posedge pclk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge pclk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        @(negedge pclk);
        #1;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge pclk) begin
        if (!reset) begin
            if (tx_data_valid) begin
                beat_t e;
                run_len++;
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("tx_data", tx_data, e.d);
                    chk("tx_datak", tx_datak, e.k);
                end
            end else begin
                if (run_len != 0) last_run = run_len;
                run_len = 0;
                chk("idle_data", tx_data, {4{IDLE}});
                chk("idle_datak", tx_datak, 0);
            end
            chk("busy_vs_valid", busy, tx_data_valid);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset     = 1'b1;
        width_sel = 2'd2;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_datak  = 4'h0;
        repeat (3) @(posedge pclk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_tx_data", tx_data, {4{IDLE}});
        chk("rst_tx_datak", tx_datak, 0);
        chk("rst_valid", tx_data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge pclk);
        #1;

        // 32b back-to-back
        width_sel = 2'd2;
        send(32'h03020100, 4'b0001, w);
        chk("b2b32_ready_mid", in_ready, 1);
        send(32'h07060504, 4'b0000, w);
        chk("b2b32_waits", w, 0);
        in_valid = 1'b0;
        drain();
        chk("b2b32_run", last_run, 2);

        // 8b single dword with ready profile
        width_sel = 2'd0;
        send(32'hBC1C2D3E, 4'b1000, w);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("8b_in_ready", in_ready, (i == 3) ? 1 : 0);
            @(posedge pclk);
            #1;
        end
        drain();
        chk("8b_run", last_run, 4);

        // 16b two dwords with in_valid held
        width_sel = 2'd1;
        send(32'h44332211, 4'b0000, w);
        send(32'h88776655, 4'b0101, w);
        chk("16b_waits", w, 1);
        in_valid = 1'b0;
        drain();
        chk("16b_run", last_run, 4);

        // width change mid 8b dword
        width_sel = 2'd0;
        send(32'h11223344, 4'b0110, w);
        in_valid = 1'b0;
        @(posedge pclk);
        #1;
        @(posedge pclk);
        #1;
        width_sel = 2'd2;
        send(32'hAABBCCDD, 4'b1001, w);
        in_valid = 1'b0;
        drain();
        chk("wchg_run", last_run, 5);

        // async reset during beat 1 of an 8b dword
        width_sel = 2'd0;
        send(32'h55667788, 4'b1111, w);
        in_valid = 1'b0;
        @(posedge pclk);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", tx_data_valid, 0);
        chk("arst_data", tx_data, {4{IDLE}});
        chk("arst_datak", tx_datak, 0);
        chk("arst_busy", busy, 0);
        q.delete();
        @(posedge pclk);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        repeat (6) @(posedge pclk);
        #1;

        // reserved width behaves as 32b
        width_sel = 2'd3;
        send(32'h12345678, 4'b0010, w);
        in_valid = 1'b0;
        drain();
        chk("rsv_run", last_run, 1);

        repeat (3) @(posedge pclk);
        chk("final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_tx_width_adapter.md
Name: pipe_tx_width_adapter

Overview:
Sits between the MAC-side TX symbol stream and the PIPE TxData bus. It accepts one 32-bit symbol dword per handshake, with per-byte K flags. It slices the dword onto the PIPE TxData lanes at the runtime-selected PIPE bus width (8, 16 or 32 bits, per pipe_data_width_e). It drives TxDataValid and applies backpressure to the MAC while a dword is being serialised.

Parameters:
IDLE_FILL, 8'h00, byte value driven on every unused or idle tx_data byte lane; tx_datak is 0 on those lanes.

Ports:
pclk  input  1  PIPE clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
width_sel  input  2  PIPE width select: 0=8b, 1=16b, 2=32b, 3=reserved (treated as 32b)
in_valid  input  1  MAC dword valid
in_ready  output  1  adapter can accept dword this cycle
in_data  input  32  symbol dword; byte0=[7:0] is transmitted first
in_datak  input  4  K flag per byte; bit i belongs to byte i
tx_data  output  32  PIPE TxData; active lanes in the low bits
tx_datak  output  4  PIPE TxDataK per active byte lane
tx_data_valid  output  1  PIPE TxDataValid
busy  output  1  a dword is held and not yet fully sent

Behaviour:
- Reset (async assert, sync release): tx_data = {4{IDLE_FILL}}, tx_datak = 0, tx_data_valid = 0, busy = 0, held dword discarded, beat counter = 0. in_ready = 1 once reset is deasserted.
- State: EMPTY or SENDING. Holds one 32-bit data register, one 4-bit K register, the latched width (wl), and a 2-bit beat counter (bc).
- Beats per dword: wl=8b → 4, wl=16b → 2, wl=32b → 1.
- Accept: in_valid && in_ready at edge N loads the dword and latches wl from width_sel.
  - First beat appears on tx_* at cycle N+1 (registered outputs, latency 1).
- width_sel is sampled only at accept. Changes while SENDING take effect on the next dword.
- Beat k output, where k = bc:
  - 8b: tx_data[7:0] = byte k; tx_datak[0] = K[k].
  - 16b: tx_data[15:0] = bytes {2k+1, 2k}; tx_datak[1:0] = K[2k+1:2k].
  - 32b: full dword and all 4 K bits.
  - Lanes above the active width = IDLE_FILL, with K = 0.
- tx_data_valid = 1 exactly on cycles presenting a beat. Otherwise 0, tx_data = {4{IDLE_FILL}}, tx_datak = 0.
- in_ready = EMPTY || (SENDING && current beat is the last beat). This allows back-to-back dwords with no gap.
  - Full throughput in 32b mode: 1 dword per cycle.
  - 8b: 1 dword per 4 cycles; 16b: 1 dword per 2 cycles.
- Last beat with no new accept: next cycle state = EMPTY, tx_data_valid = 0.
- Last beat with a simultaneous accept: the new dword's beat 0 follows immediately, bc resets to 0, and the new width is latched.
- busy = SENDING, i.e. the held dword has beats remaining, including the beat on tx this cycle.
- in_valid while in_ready = 0: the dword is not taken. The MAC holds in_data/in_datak stable until accepted; the adapter does not check this.
- Reserved width_sel=3: behaves exactly as 32b.
- Reset mid-dword: remaining beats are dropped and no further tx_data_valid appears. After release, the adapter starts EMPTY.
- No X propagation: when in_valid = 0, in_data/in_datak are not sampled.

Test Plan:
- Reset, then 32b mode, dwords 0x03020100 (K=4'b0001) and 0x07060504 (K=0) back-to-back → tx_data_valid high for 2 consecutive cycles starting 1 cycle after the first accept; tx_data = 0x03020100/tx_datak = 4'b0001, then 0x07060504/tx_datak = 0; in_ready stays 1.
- 8b mode, dword 0xBC1C2D3E, K=4'b1000 → 4 beats: tx_data[7:0] = 3E, 2D, 1C, BC; tx_datak[0] = 0, 0, 0, 1; tx_data[31:8] = IDLE_FILL lanes; in_ready low for the first 3 beat cycles and high on the 4th.
- 16b mode, two dwords 0x44332211 and 0x88776655 with in_valid held → tx_data[15:0] = 2211, 4433, 6655, 8877 on 4 consecutive cycles with no gap.
- Change width_sel from 8b to 32b during beat 2 of an 8b dword → remaining beats stay 8b; the next dword (0xAABBCCDD) is sent as one 32-bit beat.
- Assert reset during beat 1 of an 8b dword → tx_data_valid = 0 and tx_data = {4{IDLE_FILL}} immediately (async); no residual beats after release; in_ready = 1.
- width_sel = 3 with dword 0x12345678 → single 32-bit beat 0x12345678, identical to 32b mode.
